// File: rtl/mdu_pkg.sv
// Shared op-code encodings and FSM state type for the multiply/divide unit.
// Decoder and hazard logic import this to decode MDU ops and stall on busy.
package mdu_pkg;

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MTHI  = 4'd4;
   localparam logic [3:0] OP_MTLO  = 4'd5;
   localparam logic [3:0] OP_MADD  = 4'd6;
   localparam logic [3:0] OP_MADDU = 4'd7;
   localparam logic [3:0] OP_MSUB  = 4'd8;
   localparam logic [3:0] OP_MSUBU = 4'd9;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit; result computed at issue, committed after MULT_CYCLES/DIV_CYCLES.
// Latency: busy high exactly N cycles, new hi/lo visible first cycle busy is low; MTHI/MTLO take one edge.
// Backpressure: starts are dropped while busy or with cancel; MADD*/MSUB* only with MULT_DIV_UNIT_MADD_EN.
import mdu_pkg::*;

module mult_div_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [5:0]       MULT_CNT = 6'(MULT_CYCLES);
   localparam logic [5:0]       DIV_CNT  = 6'(DIV_CYCLES);
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   mdu_state_t         state_q, state_d;
   logic [5:0]         cnt_q, cnt_d;
   logic [2*WIDTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

   logic [2*WIDTH-1:0] prod_s, prod_u, div_s, div_u;
   logic [WIDTH-1:0]   abs_a, abs_b, abs_b_nz, b_nz;
   logic [WIDTH-1:0]   mag_q, mag_r, quo_s, rem_s;

   // Signed divide works on magnitudes, then restores signs: quotient truncates
   // toward zero, remainder follows the dividend.
   always_comb begin
      prod_s   = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
      prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      abs_a    = a[WIDTH-1] ? -a : a;
      abs_b    = b[WIDTH-1] ? -b : b;
      abs_b_nz = (abs_b == '0) ? ONE : abs_b;
      b_nz     = (b == '0) ? ONE : b;
      mag_q    = abs_a / abs_b_nz;
      mag_r    = abs_a % abs_b_nz;
      quo_s    = (a[WIDTH-1] ^ b[WIDTH-1]) ? -mag_q : mag_q;
      rem_s    = a[WIDTH-1] ? -mag_r : mag_r;

      if (b == '0)
         div_s = {a, {WIDTH{1'b1}}};
      else if (a == MIN_NEG && b == '1)
         div_s = {{WIDTH{1'b0}}, MIN_NEG};
      else
         div_s = {rem_s, quo_s};

      if (b == '0)
         div_u = {a, {WIDTH{1'b1}}};
      else
         div_u = {a % b_nz, a / b_nz};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (start && !cancel) begin
               case (op)
                  OP_MULT:  begin pend_d = prod_s; cnt_d = MULT_CNT; state_d = RUN; end
                  OP_MULTU: begin pend_d = prod_u; cnt_d = MULT_CNT; state_d = RUN; end
                  OP_DIV:   begin pend_d = div_s;  cnt_d = DIV_CNT;  state_d = RUN; end
                  OP_DIVU:  begin pend_d = div_u;  cnt_d = DIV_CNT;  state_d = RUN; end
                  OP_MTHI:  hi_d = a;
                  OP_MTLO:  lo_d = a;
`ifdef MULT_DIV_UNIT_MADD_EN
                  OP_MADD:  begin pend_d = {hi_q, lo_q} + prod_s; cnt_d = MULT_CNT; state_d = RUN; end
                  OP_MADDU: begin pend_d = {hi_q, lo_q} + prod_u; cnt_d = MULT_CNT; state_d = RUN; end
                  OP_MSUB:  begin pend_d = {hi_q, lo_q} - prod_s; cnt_d = MULT_CNT; state_d = RUN; end
                  OP_MSUBU: begin pend_d = {hi_q, lo_q} - prod_u; cnt_d = MULT_CNT; state_d = RUN; end
`endif
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (cancel) begin
               state_d = IDLE;
               cnt_d   = '0;
               pend_d  = '0;
            end else if (cnt_q <= 6'd1) begin
               hi_d    = pend_q[2*WIDTH-1:WIDTH];
               lo_d    = pend_q[WIDTH-1:0];
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q == RUN);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus random bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

   localparam int NM = 5;
   localparam int ND = 10;

   logic        clk = 1'b0;
   logic        reset, start, cancel;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi, lo;

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] m_hi, m_lo;

   mult_div_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit madd_en();
`ifdef MULT_DIV_UNIT_MADD_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // Busy length of an op per the architectural rules.
   function automatic int op_cycles(input logic [3:0] o);
      if (o <= 4'd1) return NM;
      if (o == 4'd2 || o == 4'd3) return ND;
      if (o >= 4'd6 && o <= 4'd9 && madd_en()) return NM;
      return 0;
   endfunction

   // Resulting {hi,lo} computed with plain wide arithmetic.
   function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] h, input logic [31:0] l);
      longint      sx, sy, q, r;
      logic [63:0] ps, pu, res;
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      ps  = 64'(sx * sy);
      pu  = 64'(x) * 64'(y);
      res = {h, l};
      case (o)
         4'd0: res = ps;
         4'd1: res = pu;
         4'd2: begin
            if (y == 0) res = {x, 32'hFFFF_FFFF};
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
            else begin
               q = sx / sy;
               r = sx % sy;
               res = {r[31:0], q[31:0]};
            end
         end
         4'd3: res = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
         4'd4: res = {x, l};
         4'd5: res = {h, x};
         4'd6: if (madd_en()) res = {h, l} + ps;
         4'd7: if (madd_en()) res = {h, l} + pu;
         4'd8: if (madd_en()) res = {h, l} - ps;
         4'd9: if (madd_en()) res = {h, l} - pu;
         default: ;
      endcase
      return res;
   endfunction

   task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      int n;
      logic [63:0] exp;
      n   = op_cycles(o);
      exp = model(o, x, y, m_hi, m_lo);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         check({tag, "_busy"}, 64'(busy), 64'd1);
         check({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
         @(negedge clk);
      end
      check({tag, "_idle"}, 64'(busy), 64'd0);
      check({tag, "_hilo"}, {hi, lo}, exp);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
   endtask

   initial begin
      logic [3:0]  ro;
      logic [31:0] rx, ry;
      int          sel;
      reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
      m_hi = '0; m_lo = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      reset = 1'b0;

      run_op("mult", 4'd0, 32'hFFFF_FFFE, 32'd3);
      check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      run_op("div", 4'd2, -32'sd7, 32'd2);
      check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("divu0", 4'd3, 32'd7, 32'd0);
      check("divu0_const", {hi, lo}, {32'd7, 32'hFFFF_FFFF});
      run_op("div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("mthi", 4'd4, 32'h1234, 32'd0);
      check("mthi_const", 64'(hi), 64'h1234);

      // MTLO and a second MULT issued while busy must both be ignored.
      @(negedge clk);
      start = 1'b1; op = 4'd1; a = 32'd6; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; op = 4'd5; a = 32'hABCD;
      @(negedge clk);
      op = 4'd0; a = 32'd100; b = 32'd100;
      @(negedge clk);
      start = 1'b0;
      for (int i = 4; i < NM; i++) @(negedge clk);
      check("busyign_last", 64'(busy), 64'd1);
      @(negedge clk);
      check("busyign_idle", 64'(busy), 64'd0);
      check("busyign_hilo", {hi, lo}, 64'd42);
      m_hi = 32'd0; m_lo = 32'd42;

      // Cancel in busy cycle 2 together with a start.
      @(negedge clk);
      start = 1'b1; op = 4'd0; a = 32'd3; b = 32'd4;
      @(negedge clk);
      start = 1'b0;
      check("cancel_b1", 64'(busy), 64'd1);
      @(negedge clk);
      cancel = 1'b1; start = 1'b1; op = 4'd4; a = 32'hDEAD;
      @(negedge clk);
      cancel = 1'b0; start = 1'b0;
      check("cancel_idle", 64'(busy), 64'd0);
      check("cancel_hilo", {hi, lo}, {m_hi, m_lo});
      repeat (NM + 2) @(negedge clk);
      check("cancel_nocommit", {hi, lo}, {m_hi, m_lo});
      check("cancel_stayidle", 64'(busy), 64'd0);

      // Start with cancel while idle is dropped, including MTLO.
      @(negedge clk);
      start = 1'b1; cancel = 1'b1; op = 4'd5; a = 32'h55;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      check("idlecancel_lo", 64'(lo), 64'(m_lo));
      check("idlecancel_busy", 64'(busy), 64'd0);

      run_op("madd_hi", 4'd4, 32'd0, 32'd0);
      run_op("madd_lo", 4'd5, 32'hFFFF_FFFF, 32'd0);
      run_op("maddu", 4'd7, 32'd1, 32'd1);
      if (madd_en()) check("maddu_const", {hi, lo}, {32'd1, 32'd0});
      else           check("maddu_const", {hi, lo}, {32'd0, 32'hFFFF_FFFF});

      // Reset in busy cycle 3 of a divide.
      run_op("pre_rst", 4'd5, 32'h77, 32'd0);
      @(negedge clk);
      start = 1'b1; op = 4'd2; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rstrun_b3", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rstrun_busy", 64'(busy), 64'd0);
      check("rstrun_hilo", {hi, lo}, 64'd0);
      repeat (ND + 2) @(negedge clk);
      check("rstrun_nocommit", {hi, lo}, 64'd0);
      m_hi = '0; m_lo = '0;

      for (int i = 0; i < 30; i++) begin
         ro  = 4'($urandom_range(0, 11));
         rx  = $urandom;
         ry  = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) ry = '0;
         if (sel == 1) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
         if (sel == 2) ry = 32'($urandom_range(1, 20));
         if (sel == 3) ry = -32'($urandom_range(1, 20));
         run_op("rand", ro, rx, ry);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
